// File: rtl/uart_parity_engine.sv
// uart_parity_engine: parity generator/checker for UART TX (parallel word) and RX (serial bits)
module uart_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic [LEN_W-1:0]      DATA_LEN,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  start,
    input  logic                  bit_vld,
    input  logic                  bit_in,
    input  logic                  chk_vld,
    input  logic                  rx_par_bit,
    output logic                  busy,
    output logic                  par_valid,
    output logic                  par_bit,
    output logic                  par_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_WIDTH);

    state_t           state_q;
    logic             en_q;
    logic [1:0]       typ_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             acc_q;
    logic             err_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] cnt_d;
    logic             xor_d;
    logic             par_w;

    // clamp the requested length and fold the parallel word down to its parity
    always_comb begin
        len_d = (DATA_LEN == '0 || DATA_LEN > FULL_LEN) ? FULL_LEN : DATA_LEN;
        cnt_d = cnt_q + LEN_W'(1);
        xor_d = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (i < int'(len_d))
                xor_d = xor_d ^ P_DATA[i];
        par_w = (state_q == DONE) && en_q &&
                (typ_q == 2'b00 ? acc_q : typ_q == 2'b01 ? ~acc_q : typ_q == 2'b10);
    end

    // frame FSM: commands abort any work, serial bits accumulate, checks set a sticky error
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            typ_q   <= 2'b00;
            len_q   <= FULL_LEN;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (load || start) begin
            en_q    <= PAR_EN;
            typ_q   <= PAR_TYP;
            len_q   <= len_d;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= load && PAR_EN && xor_d;
            state_q <= !PAR_EN ? IDLE : load ? DONE : ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (bit_vld) begin
                    acc_q <= acc_q ^ bit_in;
                    cnt_q <= cnt_d;
                    if (cnt_d == len_q)
                        state_q <= DONE;
                end
                DONE: if (chk_vld && rx_par_bit != par_w)
                    err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy      = state_q == ACCUM;
    assign par_valid = state_q == DONE;
    assign par_bit   = par_w;
    assign par_err   = err_q;
endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity generator/checker for the UART TX and RX paths. It accepts a frame either as a parallel word (TX) or as a stream of sampled bits (RX). It supports even, odd, mark and space parity over a runtime-selectable data length, and compares a received parity bit against the computed one. It sits between the UART FSMs and the serializer/sampler, and replaces the fixed 8-bit combinational parity calculator.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame (≥ 2)
- LEN_W, $clog2(DATA_WIDTH+1): width of the length field and the bit counter
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-low reset
- PAR_EN  in  1  parity enable; sampled on start/load
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0); sampled on start/load
- DATA_LEN  in  LEN_W  data bits per frame; 0 or > DATA_WIDTH is treated as DATA_WIDTH; sampled on start/load
- load  in  1  parallel capture of P_DATA
- P_DATA  in  DATA_WIDTH  parallel data; only bits [DATA_LEN-1:0] count
- start  in  1  begin serial accumulation
- bit_vld  in  1  bit_in is valid this cycle
- bit_in  in  1  serial data bit, LSB first
- chk_vld  in  1  rx_par_bit is valid this cycle
- rx_par_bit  in  1  received parity bit
- busy  out  1  serial accumulation in progress
- par_valid  out  1  par_bit holds the final parity
- par_bit  out  1  computed parity bit
- par_err  out  1  sticky parity mismatch flag

## Operation
- States:
  - IDLE: reset state.
  - ACCUM: serial accumulation in progress.
  - DONE: parity result available.
- Config latch: PAR_EN, PAR_TYP and the clamped length are registered on every accepted start or load. The outputs use only the latched copies.
- Command priority: load > start > bit_vld/chk_vld.
  - Both commands are accepted in any state, and either one aborts current work.
  - On acceptance: accumulator cleared, counter cleared, par_err cleared, par_valid cleared.
- load with latched-to-be PAR_EN=1: accumulator ← XOR of P_DATA masked to the length; next state DONE.
- start with PAR_EN=1: next state ACCUM.
- Either command with PAR_EN=0: next state IDLE.
- ACCUM, on each bit_vld: accumulator ^= bit_in, counter += 1. When the counter reaches the latched length, next state is DONE. bit_vld outside ACCUM is ignored.
- par_bit by latched type:
  - even: accumulator
  - odd: ~accumulator
  - mark: 1
  - space: 0
  - par_bit is forced to 0 when not in DONE.
- DONE, on chk_vld: par_err is set if rx_par_bit ≠ par_bit. Once set, par_err stays set until the next start, load or reset. chk_vld outside DONE is ignored.
- DONE persists until the next start or load.

## Timing
- Reset (RST=0 at a rising edge): state IDLE, busy=0, par_valid=0, par_bit=0, par_err=0, accumulator=0, counter=0, latched config = even, DATA_WIDTH, disabled.
- load at edge N: par_valid=1 and par_bit correct after edge N (latency 1).
- start at edge N: busy=1 after edge N. The first bit_vld is accepted at edge N+1 or later.
- Serial mode, last bit_vld at edge M: busy=0, par_valid=1, par_bit correct after edge M. Minimum latency from start is length+1 edges.
- chk_vld at edge K in DONE: par_err is updated after edge K.
- start and bit_vld in the same cycle: the bit is dropped and accumulation restarts.
- load and start in the same cycle: load wins.
- RST low mid-ACCUM: all state is cleared and partial parity is lost. A later chk_vld is ignored until a new frame completes.
- Counter width LEN_W holds DATA_WIDTH exactly, so it never wraps within a frame.

## Test plan
- Parallel even: reset, load P_DATA=8'hB5, DATA_LEN=8, PAR_TYP=00 → after 1 cycle par_valid=1, par_bit=1. Same data with PAR_TYP=01 → par_bit=0.
- Serial length-7 odd: start, DATA_LEN=7, PAR_TYP=01, bits 1,0,1,1,0,0,0 with idle gaps between bit_vld → busy stays 1 for exactly 7 accepted bits, then par_valid=1, par_bit=0.
- Mask and clamp:
  - load P_DATA=8'hFF, DATA_LEN=5, even → par_bit=1.
  - DATA_LEN=0 → treated as 8, par_bit=0.
- Check: after the serial case, chk_vld with rx_par_bit=1 → par_err=1 and stays 1 through a further chk_vld with rx_par_bit=0. The next start clears it.
- Mark/space/disabled:
  - PAR_TYP=10 → par_bit=1 regardless of data.
  - PAR_TYP=11 → par_bit=0 regardless of data.
  - PAR_EN=0 with load → par_valid stays 0, and chk_vld never sets par_err.
- Abort and reset: start, 3 bits, then start again with a bit_vld in the same cycle → the counter restarts from 0. Asserting RST=0 mid-ACCUM → all outputs return to reset values on the next edge.
